// File: rtl/fpga_config_pkg.sv
// Shared types and constants for the config table loader.
// Image layout: 4-word header, 7-word records, 1-word XOR trailer.
package fpga_config_pkg;

  localparam int HDR_WORDS = 4;
  localparam int REC_WORDS = 7;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_COUNT   = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REC,
    S_SUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [2:0] HW_MAGIC   = 3'd0;
  localparam logic [2:0] HW_VERSION = 3'd1;
  localparam logic [2:0] HW_COUNT   = 3'd2;
  localparam logic [2:0] HW_LAST    = 3'(HDR_WORDS - 1);

  localparam logic [2:0] RW_SWITCH  = 3'd0;
  localparam logic [2:0] RW_MY_IP   = 3'd1;
  localparam logic [2:0] RW_PEER_IP = 3'd2;
  localparam logic [2:0] RW_PORTS   = 3'd3;
  localparam logic [2:0] RW_MAC0    = 3'd4;
  localparam logic [2:0] RW_MAC1    = 3'd5;
  localparam logic [2:0] RW_MAC2    = 3'(REC_WORDS - 1);

  typedef struct packed {
    logic [31:0] switch_id;
    logic [31:0] my_ip;
    logic [31:0] peer_ip;
    logic [15:0] my_port;
    logic [15:0] peer_port;
    logic [47:0] my_mac;
    logic [47:0] peer_mac;
  } conn_rec_t;

  function automatic logic [15:0] bswap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/fpga_config_conn_ram.sv
// Connection table storage: one write port and one
// registered read port with a single cycle of latency.
import fpga_config_pkg::*;

module fpga_config_conn_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = $bits(conn_rec_t)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write on record completion, read on lookup request
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fpga_config_table_loader.sv
// Streams a config image over req/ack, checks it and fills the
// connection table; serves 1-cycle lookups to the packet path.
import fpga_config_pkg::*;

module fpga_config_table_loader #(
  parameter int                    MAX_CONNECTIONS = 64,
  parameter int                    IDX_WIDTH       = 6,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [31:0]           MAGIC           = 32'h41544746,
  parameter int                    TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [31:0]           hdr_version,
  output logic [IDX_WIDTH:0]    hdr_conn_count,
  output logic [31:0]           hdr_timestamp,
  input  logic                  lookup_valid,
  input  logic [IDX_WIDTH-1:0]  lookup_index,
  output logic                  lookup_rvalid,
  output logic                  lookup_miss,
  output logic [31:0]           conn_switch_id,
  output logic [31:0]           conn_my_ip,
  output logic [31:0]           conn_peer_ip,
  output logic [15:0]           conn_my_port,
  output logic [15:0]           conn_peer_port,
  output logic [47:0]           conn_my_mac,
  output logic [47:0]           conn_peer_mac
);

  localparam int CW = IDX_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state;
  logic [2:0]      sub;
  logic [CW-1:0]   rec_idx;
  logic [31:0]     csum;
  logic [TW-1:0]   tmo;
  conn_rec_t       rec_q;
  conn_rec_t       wr_rec;
  conn_rec_t       rd_rec;
  logic            xfer;
  logic            wr_en;
  logic            lk_rvalid;
  logic            lk_miss;
  logic            hit;

  assign xfer  = mem_req & mem_ack;
  assign wr_en = xfer && (state == S_REC) && (sub == RW_MAC2);

  // last record word completes the entry straight from the bus
  always_comb begin
    wr_rec = rec_q;
    wr_rec.peer_mac[31:0] = bswap32(mem_rdata);
  end

  // load sequencer: header, records, trailer, with fault exits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      err_code       <= ERR_NONE;
      hdr_version    <= '0;
      hdr_conn_count <= '0;
      hdr_timestamp  <= '0;
      sub            <= '0;
      rec_idx        <= '0;
      csum           <= '0;
      tmo            <= '0;
      rec_q          <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR;
            mem_req  <= 1'b1;
            mem_addr <= BASE_ADDR;
            err_code <= ERR_NONE;
            sub      <= '0;
            rec_idx  <= '0;
            csum     <= '0;
            tmo      <= '0;
          end
        end
        default: begin
          if (xfer) begin
            tmo      <= '0;
            csum     <= csum ^ mem_rdata;
            sub      <= sub + 3'd1;
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
            if (state == S_HDR) begin
              unique case (sub)
                HW_MAGIC: begin
                  if (mem_rdata != MAGIC) begin
                    state    <= S_ERR;
                    mem_req  <= 1'b0;
                    err_code <= ERR_MAGIC;
                  end
                end
                HW_VERSION: hdr_version <= mem_rdata;
                HW_COUNT: begin
                  hdr_conn_count <= mem_rdata[CW-1:0];
                  if (mem_rdata > 32'(MAX_CONNECTIONS)) begin
                    state    <= S_ERR;
                    mem_req  <= 1'b0;
                    err_code <= ERR_COUNT;
                  end
                end
                default: begin
                  hdr_timestamp <= mem_rdata;
                  sub           <= '0;
                  state <= (hdr_conn_count == '0) ? S_SUM : S_REC;
                end
              endcase
            end else if (state == S_REC) begin
              unique case (sub)
                RW_SWITCH:  rec_q.switch_id <= mem_rdata;
                RW_MY_IP:   rec_q.my_ip     <= mem_rdata;
                RW_PEER_IP: rec_q.peer_ip   <= mem_rdata;
                RW_PORTS: begin
                  rec_q.my_port   <= mem_rdata[15:0];
                  rec_q.peer_port <= mem_rdata[31:16];
                end
                RW_MAC0: rec_q.my_mac[47:16] <= bswap32(mem_rdata);
                RW_MAC1: begin
                  rec_q.my_mac[15:0]    <= bswap16(mem_rdata[15:0]);
                  rec_q.peer_mac[47:32] <= bswap16(mem_rdata[31:16]);
                end
                default: begin
                  sub     <= '0;
                  rec_idx <= rec_idx + CW'(1);
                  if (rec_idx + CW'(1) == hdr_conn_count)
                    state <= S_SUM;
                end
              endcase
            end else begin
              mem_req <= 1'b0;
              if (mem_rdata == csum) begin
                state <= S_DONE;
              end else begin
                state    <= S_ERR;
                err_code <= ERR_CSUM;
              end
            end
          end else if (tmo == TMO_LAST) begin
            state    <= S_ERR;
            mem_req  <= 1'b0;
            err_code <= ERR_TIMEOUT;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
      endcase
    end
  end

  assign busy  = (state == S_HDR) || (state == S_REC) || (state == S_SUM);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

  fpga_config_conn_ram #(
    .DEPTH (MAX_CONNECTIONS),
    .AW    (IDX_WIDTH),
    .DW    ($bits(conn_rec_t))
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (rec_idx[IDX_WIDTH-1:0]),
    .wdata (wr_rec),
    .re    (lookup_valid),
    .raddr (lookup_index),
    .rdata (rd_rec)
  );

  // lookup response qualifier, aligned with the RAM read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_rvalid <= 1'b0;
      lk_miss   <= 1'b0;
    end else begin
      lk_rvalid <= lookup_valid;
      lk_miss   <= (state != S_DONE) ||
                   ({1'b0, lookup_index} >= hdr_conn_count);
    end
  end

  assign hit            = lk_rvalid & ~lk_miss;
  assign lookup_rvalid  = lk_rvalid;
  assign lookup_miss    = lk_rvalid & lk_miss;
  assign conn_switch_id = hit ? rd_rec.switch_id : '0;
  assign conn_my_ip     = hit ? rd_rec.my_ip     : '0;
  assign conn_peer_ip   = hit ? rd_rec.peer_ip   : '0;
  assign conn_my_port   = hit ? rd_rec.my_port   : '0;
  assign conn_peer_port = hit ? rd_rec.peer_port : '0;
  assign conn_my_mac    = hit ? rd_rec.my_mac    : '0;
  assign conn_peer_mac  = hit ? rd_rec.peer_mac  : '0;

endmodule

// File: tb/tb_fpga_config_table_loader.sv
// Bench for the config table loader: memory model with
// ack gaps, lookup scoreboard and fault scenarios.
module tb_fpga_config_table_loader;

  localparam logic [31:0] MAGIC = 32'h41544746;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         busy, done, error;
  logic [2:0]   err_code;
  logic [31:0]  hdr_version, hdr_timestamp;
  logic [6:0]   hdr_conn_count;
  logic         lookup_valid;
  logic [5:0]   lookup_index;
  logic         lookup_rvalid, lookup_miss;
  logic [31:0]  conn_switch_id, conn_my_ip, conn_peer_ip;
  logic [15:0]  conn_my_port, conn_peer_port;
  logic [47:0]  conn_my_mac, conn_peer_mac;

  fpga_config_table_loader #(
    .MAX_CONNECTIONS (64),
    .IDX_WIDTH       (6),
    .ADDR_WIDTH      (32),
    .BASE_ADDR       (32'h0),
    .MAGIC           (MAGIC),
    .TIMEOUT_CYCLES  (255)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .hdr_version    (hdr_version),
    .hdr_conn_count (hdr_conn_count),
    .hdr_timestamp  (hdr_timestamp),
    .lookup_valid   (lookup_valid),
    .lookup_index   (lookup_index),
    .lookup_rvalid  (lookup_rvalid),
    .lookup_miss    (lookup_miss),
    .conn_switch_id (conn_switch_id),
    .conn_my_ip     (conn_my_ip),
    .conn_peer_ip   (conn_peer_ip),
    .conn_my_port   (conn_my_port),
    .conn_peer_port (conn_peer_port),
    .conn_my_mac    (conn_my_mac),
    .conn_peer_mac  (conn_peer_mac)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic         miss;
    logic [223:0] f;
  } lk_exp_t;

  typedef struct {
    int   idx;
    logic miss;
  } lk_vec_t;

  lk_exp_t     sb[$];
  logic [31:0] img [0:511];
  logic [31:0] rw  [0:63][0:6];
  logic [31:0] exp_ver, exp_ts;
  int          load_xfers = 0;
  int          addr_err = 0;
  int          gap_left = 0;
  int          gap_max = 0;
  int          stall_from = 1 << 30;
  int          lk_issued = 0;
  int          lk_seen = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [223:0] model(input int r);
    logic [47:0] mm, pm;
    mm = {rw[r][4][7:0], rw[r][4][15:8], rw[r][4][23:16],
          rw[r][4][31:24], rw[r][5][7:0], rw[r][5][15:8]};
    pm = {rw[r][5][23:16], rw[r][5][31:24], rw[r][6][7:0],
          rw[r][6][15:8], rw[r][6][23:16], rw[r][6][31:24]};
    return {rw[r][0], rw[r][1], rw[r][2],
            rw[r][3][15:0], rw[r][3][31:16], mm, pm};
  endfunction

  task automatic build(input int n, input logic [31:0] cnt,
                       input logic [31:0] mg, input logic [31:0] flip);
    logic [31:0] x;
    exp_ver = $urandom;
    exp_ts  = $urandom;
    img[0] = mg;
    img[1] = exp_ver;
    img[2] = cnt;
    img[3] = exp_ts;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < 7; k++) begin
        rw[r][k] = $urandom;
        img[4 + 7*r + k] = rw[r][k];
      end
    x = '0;
    for (int i = 0; i < 4 + 7*n; i++) x = x ^ img[i];
    img[4 + 7*n] = x ^ flip;
  endtask

  // memory model: decide ack for the coming edge
  always @(negedge clk) begin
    if (rst_n && mem_req && gap_left == 0 && load_xfers < stall_from) begin
      mem_ack   = 1'b1;
      mem_rdata = img[int'(mem_addr >> 2) % 512];
    end else begin
      mem_ack = 1'b0;
      if (mem_req && gap_left > 0) gap_left--;
    end
  end

  // transfer monitor: address sequence and next gap
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (mem_addr !== 32'(4 * load_xfers)) addr_err++;
      load_xfers++;
      gap_left = $urandom_range(0, gap_max);
    end
  end

  // lookup scoreboard: compare each response with queued expectation
  always @(negedge clk) begin
    lk_exp_t e;
    if (rst_n && lookup_rvalid) begin
      lk_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lk_spurious actual=rvalid required=idle");
      end else begin
        e = sb.pop_front();
        chk("lk_resp",
            {lookup_miss, conn_switch_id, conn_my_ip, conn_peer_ip,
             conn_my_port, conn_peer_port, conn_my_mac, conn_peer_mac},
            {e.miss, e.f});
      end
    end
  end

  task automatic issue_lk(input int idx, input logic miss);
    lk_exp_t e;
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_index = 6'(idx);
    e.miss = miss;
    e.f    = miss ? '0 : model(idx);
    sb.push_back(e);
    lk_issued++;
  endtask

  task automatic lk_end();
    @(negedge clk);
    lookup_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lk_drain", 256'(sb.size()), 256'(0));
    chk("lk_count", 256'(lk_seen), 256'(lk_issued));
    chk("lk_pulse", 256'(lookup_rvalid), 256'(0));
  endtask

  task automatic do_start();
    @(negedge clk);
    load_xfers = 0;
    addr_err   = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL wait_end actual=busy required=finished");
    end
  endtask

  lk_vec_t vt [5];
  int      hold_bad;
  int      stall_cyc;

  initial begin
    vt[0] = '{1, 1'b0};
    vt[1] = '{0, 1'b0};
    vt[2] = '{2, 1'b1};
    vt[3] = '{63, 1'b1};
    vt[4] = '{1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    lookup_valid = 1'b0;
    lookup_index = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outs", {mem_req, busy, done, error, err_code},
        {1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    chk("rst_hdr", {hdr_version, hdr_conn_count, hdr_timestamp}, '0);
    issue_lk(0, 1'b1);
    lk_end();

    // valid image, ack every cycle
    build(2, 32'd2, MAGIC, 32'h0);
    do_start();
    chk("busy_load", {busy, done, error}, {1'b1, 1'b0, 1'b0});
    wait_end(200);
    chk("ok_state", {done, error, err_code}, {1'b1, 1'b0, 3'd0});
    chk("ok_xfers", 256'(load_xfers), 256'(19));
    chk("ok_addrs", 256'(addr_err), 256'(0));
    chk("ok_hdr", {hdr_version, hdr_conn_count, hdr_timestamp},
        {exp_ver, 7'd2, exp_ts});
    repeat (4) @(negedge clk);
    chk("ok_idle_bus", {mem_req, busy, 7'(load_xfers)},
        {1'b0, 1'b0, 7'd19});
    foreach (vt[i]) issue_lk(vt[i].idx, vt[i].miss);
    lk_end();

    // bad magic
    build(2, 32'd2, 32'h12345678, 32'h0);
    do_start();
    chk("mag_done_clr", done, 1'b0);
    wait_end(200);
    repeat (4) @(negedge clk);
    chk("mag_err", {done, error, err_code}, {1'b0, 1'b1, 3'd1});
    chk("mag_xfers", {mem_req, 8'(load_xfers)}, {1'b0, 8'd1});

    // connection count too large
    build(2, 32'd65, MAGIC, 32'h0);
    do_start();
    wait_end(200);
    repeat (2) @(negedge clk);
    chk("cnt_err", {done, error, err_code}, {1'b0, 1'b1, 3'd2});
    chk("cnt_xfers", {mem_req, 8'(load_xfers)}, {1'b0, 8'd3});
    issue_lk(0, 1'b1);
    lk_end();

    // checksum trailer corrupted
    build(2, 32'd2, MAGIC, 32'h1);
    do_start();
    wait_end(200);
    chk("sum_err", {done, error, err_code}, {1'b0, 1'b1, 3'd3});
    chk("sum_xfers", 256'(load_xfers), 256'(19));
    issue_lk(0, 1'b1);
    issue_lk(1, 1'b1);
    lk_end();

    // ack withheld from word 5 onward
    build(2, 32'd2, MAGIC, 32'h0);
    stall_from = 5;
    do_start();
    hold_bad = 0;
    stall_cyc = 0;
    for (int i = 0; i < 600; i++) begin
      if (error) break;
      if (mem_req && load_xfers == 5) begin
        stall_cyc++;
        if (mem_addr !== 32'd20) hold_bad++;
      end
      @(negedge clk);
    end
    chk("tmo_err", {done, error, err_code, mem_req},
        {1'b0, 1'b1, 3'd4, 1'b0});
    chk("tmo_cycles", 256'(stall_cyc), 256'(255));
    chk("tmo_addr_hold", 256'(hold_bad), 256'(0));
    chk("tmo_xfers", 256'(load_xfers), 256'(5));
    stall_from = 1 << 30;

    // reset in the middle of a load with random ack gaps
    gap_max = 5;
    build(2, 32'd2, MAGIC, 32'h0);
    do_start();
    for (int i = 0; i < 500; i++) begin
      if (load_xfers >= 10) break;
      @(negedge clk);
    end
    chk("rst_reach10", 256'(load_xfers), 256'(10));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", {mem_req, busy, done, error, err_code}, '0);
    @(negedge clk);
    chk("rst_no_req", {mem_req, 8'(load_xfers)}, {1'b0, 8'd10});
    rst_n = 1'b1;
    @(negedge clk);
    build(2, 32'd2, MAGIC, 32'h0);
    do_start();
    wait_end(1000);
    chk("rst_reload", {done, error, err_code}, {1'b1, 1'b0, 3'd0});
    chk("rst_xfers", 256'(load_xfers), 256'(19));
    chk("rst_addrs", 256'(addr_err), 256'(0));
    issue_lk(2, 1'b1);
    issue_lk(0, 1'b0);
    issue_lk(1, 1'b0);
    lk_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpga_config_table_loader.md
Name:
fpga_config_table_loader

Overview:
- Successor to the single-record config reader. On `start`, streams the whole binary config image from memory: 16-byte header, N 28-byte connection records, and a 32-bit XOR checksum trailer.
- Memory is accessed through a variable-latency req/ack handshake. All records are decoded into an on-chip connection table.
- Integrity checks: magic, connection count and checksum.
- Serves random-access lookups with fixed 1-cycle latency to the packet-path logic.

Parameters:
- MAX_CONNECTIONS, 64: table depth.
- IDX_WIDTH, 6: lookup index width, equal to clog2(MAX_CONNECTIONS).
- ADDR_WIDTH, 32: byte-address width.
- BASE_ADDR, 0: byte address of image word 0.
- MAGIC, 32'h41544746: required header word 0.
- TIMEOUT_CYCLES, 255: maximum cycles mem_req may wait for mem_ack.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin load; ignored while busy.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  byte address; stable while mem_req is high and mem_ack is low.
- mem_ack  in  1  read completes this cycle.
- mem_rdata  in  32  data, valid when mem_ack is high.
- busy  out  1  load in progress.
- done  out  1  level; table valid.
- error  out  1  level; load failed.
- err_code  out  3  1=magic, 2=count, 3=checksum, 4=timeout; 0 otherwise.
- hdr_version  out  32  header word 1.
- hdr_conn_count  out  IDX_WIDTH+1  header word 2, truncated.
- hdr_timestamp  out  32  header word 3.
- lookup_valid  in  1  lookup request.
- lookup_index  in  IDX_WIDTH  record index.
- lookup_rvalid  out  1  1-cycle pulse, one cycle after lookup_valid.
- lookup_miss  out  1  qualifies lookup_rvalid.
- conn_switch_id, conn_my_ip, conn_peer_ip  out  32 each.
- conn_my_port, conn_peer_port  out  16 each.
- conn_my_mac, conn_peer_mac  out  48 each.

Behaviour:
- Reset: all outputs 0, state IDLE, all table-valid state cleared. Reset mid-load aborts immediately, with no further mem_req.
- States:
  - IDLE -> HDR on start.
  - HDR -> REC after word 3.
  - REC -> SUM after word 3+7N.
  - SUM -> DONE on checksum match.
  - Any fetch state -> ERR on a fault.
  - DONE and ERR -> HDR on start; done, error and err_code clear that cycle.
- Word index w runs 0..4+7N; mem_addr = BASE_ADDR + 4*w.
- Handshake:
  - mem_req stays high through the load.
  - A transfer occurs on each cycle with mem_req and mem_ack both high; w advances the next cycle.
  - mem_req drops the cycle a terminal word is accepted.
  - Exactly one transfer per word; no speculative reads.
- Early checks:
  - After word 0: if word != MAGIC, go to ERR with code 1 and issue no more reads.
  - After word 2: if word > MAX_CONNECTIONS, go to ERR with code 2.
  - N=0 is legal; the checksum word is w=4.
- Checksum:
  - Running XOR of words 0..3+7N.
  - Trailer word mismatch -> ERR with code 3.
- Timeout:
  - Counter resets on each transfer.
  - If it reaches TIMEOUT_CYCLES while mem_req is high, go to ERR with code 4 and drop mem_req.
- Header outputs update as each header word arrives.
- Record decode (words r0..r6):
  - switch_id = r0; my_ip = r1; peer_ip = r2.
  - my_port = r3[15:0]; peer_port = r3[31:16].
  - my_mac = {r4[7:0], r4[15:8], r4[23:16], r4[31:24], r5[7:0], r5[15:8]}.
  - peer_mac = {r5[23:16], r5[31:24], r6[7:0], r6[15:8], r6[23:16], r6[31:24]}.
  - The entry is written to the table on r6 acceptance.
- Lookup:
  - lookup_rvalid=1 in the cycle after lookup_valid.
  - lookup_miss=1 if not done, or if index >= hdr_conn_count; fields read 0 on a miss.
  - Back-to-back lookups are allowed every cycle.
  - Lookups during a reload miss; the table contents are no longer trusted.
- busy=1 in HDR/REC/SUM only. done and error are mutually exclusive.

Decomposition:
- Package fpga_config_pkg holds:
  - HDR_WORDS=4 and REC_WORDS=7.
  - Err-code constants and the state enum.
  - Record field offset constants.
  - Packed record struct (224-bit decoded entry).
- Sub-module fpga_config_conn_ram: simple dual-port RAM, MAX_CONNECTIONS x 224 bits, one write port, registered read port with 1-cycle latency.

Test Plan:
- Valid image, N=2, ack every cycle -> exactly 19 transfers at addresses 0..72; done=1. A lookup of index 1 returns the programmed fields with miss=0 and MACs byte-ordered as specified.
- Word 0 = 0x12345678 -> 1 transfer; error=1, err_code=1; mem_req low afterwards.
- Word 2 = 65 -> 3 transfers; err_code=2. Lookup of index 0 -> rvalid=1, miss=1.
- Checksum trailer XOR-flipped by 1 -> err_code=3 after the final transfer; all lookups miss.
- mem_ack withheld from word 5 onward -> err_code=4 after 255 cycles; mem_addr held at 20 until the timeout.
- rst_n low at word 10, then a restart with random ack gaps (0-5 cycles) -> clean load with done=1. Lookup index 2 with N=2 -> miss.
